// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array controller and its result drain.
//   drain_state_e : drain FSM states (idle, issuing reads, waiting for last accept)
//   DRAIN_DEPTH   : entries in the drain output buffer; also the read credit limit
//   DRAIN_CNT_W   : width of an occupancy count for that buffer
package systolic_pkg;

    localparam int unsigned DRAIN_DEPTH = 2;
    localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush
    } drain_state_e;

endpackage

// File: rtl/systolic_drain_fifo.sv
// Two-entry output buffer for the result drain. Holds {last, data} words.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write push_data_i this cycle (caller guarantees space)
//   push_data_i   : word to write
//   pop_i         : consume the head word (ignored when empty)
//   valid_o       : buffer non-empty
//   head_o        : oldest word; zero after reset
//   count_o       : current occupancy
module systolic_drain_fifo
    import systolic_pkg::*;
#(
    parameter int unsigned Width = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [Width-1:0]       head_o,
    output logic [DRAIN_CNT_W-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DRAIN_DEPTH);

    logic [Width-1:0]       mem_q [DRAIN_DEPTH];
    logic [Width-1:0]       mem_d [DRAIN_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DRAIN_CNT_W-1:0] count_q, count_d;
    logic                   pop_ok;

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign pop_ok  = pop_i && valid_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        count_d = count_q + DRAIN_CNT_W'(push_i) - DRAIN_CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Streams one size x size result matrix out of a systolic array, row-major or
// column-major, through a valid/ready interface with full backpressure.
//   clk, rst          : clock, asynchronous active-high reset
//   start_val/rdy     : start handshake; start_rdy is high only when idle
//   start_col_major   : drain order, sampled on the start handshake
//   out_rsel/out_csel : array element select; b_s_in returns it one cycle later
//   b_s_in            : array result for the previous cycle's select
//   send_*            : result stream; send_last marks the final element
//   done              : one-cycle pulse the cycle after the final element is accepted
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned size  = 16,
    parameter int unsigned nbits = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_val,
    output logic                    start_rdy,
    input  logic                    start_col_major,
    output logic [$clog2(size)-1:0] out_rsel,
    output logic [$clog2(size)-1:0] out_csel,
    input  logic [nbits-1:0]        b_s_in,
    output logic [nbits-1:0]        send_msg,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic                    send_last,
    output logic                    done
);

    localparam int unsigned     SelW   = $clog2(size);
    localparam logic [SelW-1:0] SelMax = SelW'(size - 1);

    drain_state_e    state_q, state_d;
    logic [SelW-1:0] rsel_q, rsel_d;
    logic [SelW-1:0] csel_q, csel_d;
    logic            col_major_q, col_major_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic            done_q, done_d;

    logic [DRAIN_CNT_W-1:0] fifo_count;
    logic [nbits:0]         fifo_head;
    logic                   fifo_valid;
    logic                   fifo_pop;
    logic [2:0]             credit_use;
    logic                   issue;
    logic                   sel_last;
    logic                   head_last;

    systolic_drain_fifo #(
        .Width (nbits + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, b_s_in}),
        .pop_i       (fifo_pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign send_val  = fifo_valid;
    assign send_msg  = fifo_head[nbits-1:0];
    assign head_last = fifo_head[nbits];
    assign send_last = fifo_valid && head_last;
    assign fifo_pop  = fifo_valid && send_rdy;

    assign start_rdy = (state_q == StIdle);
    assign out_rsel  = rsel_q;
    assign out_csel  = csel_q;
    assign done      = done_q;

    // Credits: an element is either inflight in the array or sitting in the buffer.
    // An element leaving the buffer this cycle frees its slot in time for the
    // word pushed by a read issued now, which keeps 1 element/cycle with ready high.
    assign credit_use = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
    assign issue      = (state_q == StDrain) && (credit_use < 3'(DRAIN_DEPTH));
    assign sel_last   = (rsel_q == SelMax) && (csel_q == SelMax);

    always_comb begin
        state_d         = state_q;
        rsel_d          = rsel_q;
        csel_d          = csel_q;
        col_major_d     = col_major_q;
        inflight_d      = issue;
        inflight_last_d = issue && sel_last;
        done_d          = fifo_pop && head_last;

        unique case (state_q)
            StIdle: begin
                if (start_val) begin
                    state_d     = StDrain;
                    rsel_d      = '0;
                    csel_d      = '0;
                    col_major_d = start_col_major;
                end
            end
            StDrain: begin
                if (issue) begin
                    if (sel_last) begin
                        state_d = StFlush;
                    end
                    // Power-of-two size: the minor counter wraps to zero on its own.
                    if (col_major_q) begin
                        rsel_d = rsel_q + SelW'(1);
                        if (rsel_q == SelMax) begin
                            csel_d = csel_q + SelW'(1);
                        end
                    end else begin
                        csel_d = csel_q + SelW'(1);
                        if (csel_q == SelMax) begin
                            rsel_d = rsel_q + SelW'(1);
                        end
                    end
                end
            end
            StFlush: begin
                if (fifo_pop && head_last && (fifo_count == DRAIN_CNT_W'(1)) && !inflight_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            rsel_q          <= '0;
            csel_q          <= '0;
            col_major_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rsel_q          <= rsel_d;
            csel_q          <= csel_d;
            col_major_q     <= col_major_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with size=4, nbits=16. The array model
// returns (r<<8)|c one cycle after the select.
module tb_systolic_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_val = 1'b0;
    logic        start_rdy;
    logic        start_col_major = 1'b0;
    logic [1:0]  out_rsel, out_csel;
    logic [15:0] b_s_in;
    logic [15:0] send_msg;
    logic        send_val;
    logic        send_rdy = 1'b0;
    logic        send_last;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] got[$];
    int          last_cnt, last_idx, first_val_cyc, done_cyc, early_rdy, extra_hs;
    logic [3:0]  sel_hist [0:255];
    logic [15:0] msg_hist [0:255];
    logic        val_hist [0:255];

    systolic_drain #(
        .size  (4),
        .nbits (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_val       (start_val),
        .start_rdy       (start_rdy),
        .start_col_major (start_col_major),
        .out_rsel        (out_rsel),
        .out_csel        (out_csel),
        .b_s_in          (b_s_in),
        .send_msg        (send_msg),
        .send_val        (send_val),
        .send_rdy        (send_rdy),
        .send_last       (send_last),
        .done            (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) b_s_in <= {6'd0, out_rsel, 6'd0, out_csel};

    function automatic logic [15:0] exp_elem(input int i, input bit col);
        int r, c;
        r = col ? (i % 4) : (i / 4);
        c = col ? (i / 4) : (i % 4);
        return 16'((r << 8) | c);
    endfunction

    // Handshake happens on the posedge following this negedge.
    task automatic do_start(input logic col);
        @(negedge clk);
        n_cmp++;
        if (start_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_rdy_before_start got=%b exp=1", start_rdy);
        end
        start_col_major = col;
        start_val       = 1'b1;
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 low for 10 cycles then high.
    // start_mode: 0 drop start_val, 1 keep high, 2 keep high until done.
    // Cycle n is the negedge after the n-th posedge following the handshake.
    task automatic collect(input int rdy_mode, input int start_mode);
        got.delete();
        last_cnt = 0; last_idx = -1; first_val_cyc = -1; done_cyc = -1;
        early_rdy = 0; extra_hs = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n < 256) begin
                sel_hist[n] = {out_rsel, out_csel};
                msg_hist[n] = send_msg;
                val_hist[n] = send_val;
            end
            if (done) begin
                done_cyc = n;
                if (start_mode == 2) start_val = 1'b0;
                if (start_val && start_rdy) extra_hs++;
                send_rdy = 1'b0;
                break;
            end
            if (start_mode == 0) start_val = 1'b0;
            if (start_val && start_rdy) extra_hs++;
            if (start_rdy) early_rdy++;
            if (send_val && first_val_cyc < 0) first_val_cyc = n;
            case (rdy_mode)
                0:       send_rdy = 1'b1;
                1:       send_rdy = 1'($urandom_range(0, 1));
                default: send_rdy = (n > 10);
            endcase
            if (send_val && send_rdy) begin
                got.push_back(send_msg);
                if (send_last) begin
                    last_cnt++;
                    last_idx = got.size() - 1;
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({start_rdy, send_val, send_last, done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl got rdy/val/last/done=%b exp=1000",
                     {start_rdy, send_val, send_last, done});
        end
        n_cmp++;
        if ({out_rsel, out_csel} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_sel got=%b exp=0000", {out_rsel, out_csel});
        end
        n_cmp++;
        if (send_msg !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_msg got=%h exp=0000", send_msg);
        end
        rst = 1'b0;
    endtask

    task automatic test_row_major;
        do_start(1'b0);
        collect(0, 0);
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++; $display("FAIL row_count got=%0d exp=16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b0)) begin
                n_bad++; $display("FAIL row_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b0));
            end
        end
        n_cmp++;
        if (first_val_cyc != 3) begin
            n_bad++; $display("FAIL row_first_val got=%0d exp=3", first_val_cyc);
        end
        n_cmp++;
        if (done_cyc != 19) begin
            n_bad++; $display("FAIL row_done_cycle got=%0d exp=19", done_cyc);
        end
        n_cmp++;
        if (last_cnt != 1 || last_idx != 15) begin
            n_bad++; $display("FAIL row_last got cnt=%0d idx=%0d exp cnt=1 idx=15", last_cnt, last_idx);
        end
        n_cmp++;
        if (early_rdy != 0) begin
            n_bad++; $display("FAIL row_start_rdy_busy got=%0d exp=0", early_rdy);
        end
    endtask

    task automatic test_col_major;
        do_start(1'b1);
        collect(0, 0);
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++; $display("FAIL col_count got=%0d exp=16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b1)) begin
                n_bad++; $display("FAIL col_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b1));
            end
        end
        n_cmp++;
        if (done_cyc != 19 || last_idx != 15) begin
            n_bad++; $display("FAIL col_done got cyc=%0d last=%0d exp cyc=19 last=15", done_cyc, last_idx);
        end
    endtask

    task automatic test_backpressure;
        int held_bad;
        do_start(1'b0);
        collect(2, 0);
        // Two reads issued (0,0),(0,1); select then parks on (0,2).
        n_cmp++;
        if (sel_hist[3] !== 4'b0010 || sel_hist[10] !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_sel_frozen got=%b/%b exp=0010/0010", sel_hist[3], sel_hist[10]);
        end
        held_bad = 0;
        for (int n = 3; n <= 10; n++) begin
            if (val_hist[n] !== 1'b1 || msg_hist[n] !== 16'h0000) held_bad++;
        end
        n_cmp++;
        if (held_bad != 0) begin
            n_bad++; $display("FAIL bp_msg_held got bad_cycles=%0d exp=0", held_bad);
        end
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++; $display("FAIL bp_count got=%0d exp=16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b0)) begin
                n_bad++; $display("FAIL bp_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b0));
            end
        end
        n_cmp++;
        if (done_cyc < 0 || last_idx != 15) begin
            n_bad++; $display("FAIL bp_done got cyc=%0d last=%0d exp done seen, last=15", done_cyc, last_idx);
        end
    endtask

    task automatic test_random_ready;
        do_start(1'b1);
        collect(1, 0);
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++; $display("FAIL rnd_count got=%0d exp=16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b1)) begin
                n_bad++; $display("FAIL rnd_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b1));
            end
        end
        n_cmp++;
        if (last_cnt != 1 || last_idx != 15) begin
            n_bad++; $display("FAIL rnd_last got cnt=%0d idx=%0d exp cnt=1 idx=15", last_cnt, last_idx);
        end
        n_cmp++;
        if (early_rdy != 0 || done_cyc < 0) begin
            n_bad++; $display("FAIL rnd_busy got early_rdy=%0d done=%0d exp 0 and done seen", early_rdy, done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        int stray;
        do_start(1'b0);
        send_rdy = 1'b1;
        acc = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start_val = 1'b0;
            if (acc == 5) break;
            if (send_val) acc++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({send_val, start_rdy, done} !== 3'b010) begin
            n_bad++;
            $display("FAIL rstmid_outputs got val/rdy/done=%b exp=010", {send_val, start_rdy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done || send_val || !start_rdy) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++; $display("FAIL rstmid_quiet got stray=%0d exp=0", stray);
        end
        do_start(1'b0);
        collect(0, 0);
        n_cmp++;
        if (got.size() != 16 || done_cyc != 19) begin
            n_bad++; $display("FAIL rstmid_restart got cnt=%0d done=%0d exp 16/19", got.size(), done_cyc);
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b0)) begin
                n_bad++; $display("FAIL rstmid_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b0));
            end
        end
    endtask

    task automatic test_start_held;
        int busy;
        do_start(1'b0);
        collect(0, 1);
        // Only the start seen at the done cycle (back in idle) counts.
        n_cmp++;
        if (got.size() != 16 || done_cyc != 19 || extra_hs != 1) begin
            n_bad++;
            $display("FAIL held_first got cnt=%0d done=%0d hs=%0d exp 16/19/1", got.size(), done_cyc, extra_hs);
        end
        collect(0, 2);
        n_cmp++;
        if (got.size() != 16 || done_cyc != 19 || extra_hs != 0) begin
            n_bad++;
            $display("FAIL held_second got cnt=%0d done=%0d hs=%0d exp 16/19/0", got.size(), done_cyc, extra_hs);
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_cmp++;
            if (got[i] !== exp_elem(i, 1'b0)) begin
                n_bad++; $display("FAIL held_elem[%0d] got=%h exp=%h", i, got[i], exp_elem(i, 1'b0));
            end
        end
        busy = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (!start_rdy || send_val) busy++;
        end
        n_cmp++;
        if (busy != 0) begin
            n_bad++; $display("FAIL held_idle_after got busy=%0d exp=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_col_major();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
